rom_fetch_arb: RTL and testbench

ROM_FETCH_ARB -- requirements
Module: rom_fetch_arb

---
 rtl/rom_fetch_arb_pkg.sv | 6 +
 rtl/rr_pick.sv | 18 +
 rtl/rom_fetch_arb.sv | 64 ++++++
 tb/tb_rom_fetch_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_arb_pkg.sv
// rom_fetch_arb_pkg: shared FSM states, ROM geometry and port-index width
package rom_fetch_arb_pkg;
   typedef enum logic [1:0] {IDLE, READ, CAPTURE} state_t;
   localparam int ROM_ADDR_W = 14;
   localparam int IDX_W = 2;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first pending port at or after rr
module rr_pick
   import rom_fetch_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     pending,
   input  logic [IDX_W-1:0] rr,
   output logic [IDX_W-1:0] grant,
   output logic             any
);
   always_comb begin
      grant = '0;
      any = |pending;
      for (int k = N - 1; k >= 0; k--)
         if (pending[(int'(rr) + k) % N]) grant = IDX_W'((int'(rr) + k) % N);
   end
endmodule

// File: rtl/rom_fetch_arb.sv
// rom_fetch_arb: per-port one-entry byte caches filled from a shared ROM image
// through a single round-robin arbitrated read port.
module rom_fetch_arb
   import rom_fetch_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W = ROM_ADDR_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req_cs,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   output logic [NUM_PORTS*8-1:0]      rd_data,
   output logic [NUM_PORTS-1:0]        rd_valid,
   output logic                        mem_rd,
   output logic [ADDR_W+IDX_W-1:0]     mem_addr,
   input  logic [7:0]                  mem_rdata
);
   state_t state, state_n;
   logic [ADDR_W-1:0] tag [NUM_PORTS];
   logic [7:0] data [NUM_PORTS];
   logic [NUM_PORTS-1:0] tag_vld, hit, pending;
   logic [IDX_W-1:0] rr, pick, g;
   logic any;
   // mem_addr doubles as the latch for the granted port and its address
   assign g = mem_addr[ADDR_W +: IDX_W];
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign hit[i] = tag_vld[i] && tag[i] == req_addr[i*ADDR_W +: ADDR_W];
      assign rd_valid[i] = req_cs[i] & hit[i];
      assign pending[i] = req_cs[i] & ~hit[i] & ~(state != IDLE && g == IDX_W'(i));
      assign rd_data[i*8 +: 8] = data[i];
   end
   rr_pick #(.N(NUM_PORTS)) u_pick (
      .pending(pending),
      .rr(rr),
      .grant(pick),
      .any(any)
   );
   always_comb begin
      state_n = state == IDLE ? (any ? READ : IDLE) : state == READ ? CAPTURE : IDLE;
      mem_rd = state == READ;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr <= '0;
         tag_vld <= '0;
         mem_addr <= '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            tag[k] <= '0;
            data[k] <= '0;
         end
      end else begin
         state <= state_n;
         if (state == IDLE && any) mem_addr <= {pick, req_addr[int'(pick)*ADDR_W +: ADDR_W]};
         if (state == CAPTURE) begin
            data[g] <= mem_rdata;
            tag[g] <= mem_addr[ADDR_W-1:0];
            tag_vld[g] <= 1'b1;
            rr <= g == IDX_W'(NUM_PORTS - 1) ? '0 : g + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rom_fetch_arb.sv
// tb_rom_fetch_arb: table vectors, directed corner sequences and random traffic
// against a cycle-level reference model of the fetch arbiter.
module tb_rom_fetch_arb;
   logic clk, rst;
   logic [3:0] req_cs;
   logic [55:0] req_addr;
   logic [31:0] rd_data;
   logic [3:0] rd_valid;
   logic mem_rd;
   logic [15:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] rom [65536];
   int vectors = 0, miscompares = 0;

   rom_fetch_arb dut (
      .clk(clk), .rst(rst), .req_cs(req_cs), .req_addr(req_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory answers one cycle after the strobe; garbage otherwise
   always @(posedge clk) mem_rdata <= mem_rd ? rom[mem_addr] : 8'($urandom);

   // reference model: phase 0 idle, 1 strobe cycle, 2 capture cycle
   int m_phase, m_rr, m_fp;
   logic [15:0] m_maddr;
   logic [13:0] m_tag [4];
   logic m_vld [4];
   logic [7:0] m_data [4];

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_rr = 0; m_fp = 0; m_maddr = '0;
         for (int i = 0; i < 4; i++) begin m_tag[i] = '0; m_vld[i] = 1'b0; m_data[i] = '0; end
      end else if (m_phase == 0) begin
         for (int k = 0; k < 4; k++) begin
            int p;
            p = (m_rr + k) % 4;
            if (m_phase == 0 && req_cs[p] && !(m_vld[p] && m_tag[p] == req_addr[p*14 +: 14])) begin
               m_phase = 1; m_fp = p; m_maddr = {2'(p), req_addr[p*14 +: 14]};
            end
         end
      end else if (m_phase == 1) m_phase = 2;
      else begin
         m_data[m_fp] = rom[m_maddr];
         m_tag[m_fp] = m_maddr[13:0];
         m_vld[m_fp] = 1'b1;
         m_rr = (m_fp + 1) % 4;
         m_phase = 0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_cmp();
      logic [3:0] ev;
      logic [31:0] ed;
      for (int i = 0; i < 4; i++) begin
         ev[i] = req_cs[i] && m_vld[i] && m_tag[i] == req_addr[i*14 +: 14];
         ed[i*8 +: 8] = m_data[i];
      end
      chk("model_rd_valid", rd_valid, ev);
      chk("model_rd_data", rd_data, ed);
      chk("model_mem_rd", mem_rd, m_phase == 1);
      chk("model_mem_addr", mem_addr, m_maddr);
   endtask

   task automatic tick();
      @(negedge clk);
      model_cmp();
   endtask

   task automatic set_addr(input int p, input logic [13:0] a);
      req_addr[p*14 +: 14] = a;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_cs = '0; req_addr = '0;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      int port;
      logic [13:0] addr;
      logic [7:0] byt;
      logic [15:0] exp_maddr;
      logic [3:0] exp_valid;
   } vec_t;
   vec_t tbl [4];
   logic [1:0] gq [$];
   logic [13:0] a0, a3;

   initial begin
      for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
      tbl[0] = '{0, 14'h0010, 8'hA5, 16'h0010, 4'b0001};
      tbl[1] = '{1, 14'h3FFF, 8'h5A, 16'h7FFF, 4'b0010};
      tbl[2] = '{2, 14'h0000, 8'hFF, 16'h8000, 4'b0100};
      tbl[3] = '{3, 14'h2ABC, 8'h00, 16'hEABC, 4'b1000};
      rst = 1'b1; req_cs = '0; req_addr = '0;
      @(posedge clk);
      do_reset();
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_mem_rd", mem_rd, 0);
      chk("reset_mem_addr", mem_addr, 0);
      // single uncontended fetches
      for (int n = 0; n < 4; n++) begin
         rom[tbl[n].exp_maddr] = tbl[n].byt;
         do_reset();
         req_cs[tbl[n].port] = 1'b1;
         set_addr(tbl[n].port, tbl[n].addr);
         tick();
         chk("tbl_c2_mem_rd", mem_rd, 1);
         chk("tbl_c2_mem_addr", mem_addr, tbl[n].exp_maddr);
         chk("tbl_c2_rd_valid", rd_valid, 0);
         tick();
         chk("tbl_c3_mem_rd", mem_rd, 0);
         chk("tbl_c3_rd_valid", rd_valid, 0);
         tick();
         chk("tbl_c4_rd_valid", rd_valid, tbl[n].exp_valid);
         chk("tbl_c4_rd_data", rd_data[tbl[n].port*8 +: 8], tbl[n].byt);
         chk("tbl_c4_mem_addr_hold", mem_addr, tbl[n].exp_maddr);
      end
      // all four ports at once
      do_reset();
      req_cs = 4'hF;
      req_addr = {14'h0333, 14'h0222, 14'h0111, 14'h0000};
      for (int c = 2; c <= 13; c++) begin
         tick();
         if (c % 3 == 2 && c <= 11) begin
            chk("rr_mem_rd", mem_rd, 1);
            chk("rr_order", mem_addr[15:14], (c - 2) / 3);
         end else chk("rr_mem_rd_idle", mem_rd, 0);
         if (c == 12) chk("rr_valid_c12", rd_valid, 4'b0111);
         if (c == 13) chk("rr_valid_c13", rd_valid, 4'hF);
      end
      // address change while the fetch is in flight
      do_reset();
      req_cs = 4'b0010;
      set_addr(1, 14'h0100);
      tick();
      chk("chg_read", mem_addr, 16'h4100);
      set_addr(1, 14'h0101);
      tick();
      chk("chg_valid_c3", rd_valid[1], 0);
      tick();
      chk("chg_valid_c4", rd_valid[1], 0);
      chk("chg_mem_rd_c4", mem_rd, 0);
      set_addr(1, 14'h0100);
      #1;
      chk("chg_old_tag", rd_valid[1], 1);
      chk("chg_old_data", rd_data[15:8], rom[16'h4100]);
      set_addr(1, 14'h0101);
      tick();
      chk("chg_refetch_rd", mem_rd, 1);
      chk("chg_refetch_addr", mem_addr, 16'h4101);
      chk("chg_valid_c5", rd_valid[1], 0);
      tick();
      chk("chg_valid_c6", rd_valid[1], 0);
      tick();
      chk("chg_valid_c7", rd_valid[1], 1);
      chk("chg_data_c7", rd_data[15:8], rom[16'h4101]);
      // cs drop and re-assert on a cached address
      do_reset();
      req_cs = 4'b0100;
      set_addr(2, 14'h1234);
      repeat (3) tick();
      chk("cs_fill", rd_valid[2], 1);
      req_cs = '0;
      tick();
      chk("cs_low_valid", rd_valid[2], 0);
      chk("cs_low_mem_rd", mem_rd, 0);
      tick();
      req_cs = 4'b0100;
      #1;
      chk("cs_immediate", rd_valid[2], 1);
      repeat (3) begin
         tick();
         chk("cs_no_mem_rd", mem_rd, 0);
         chk("cs_still_valid", rd_valid[2], 1);
      end
      // reset during capture
      do_reset();
      req_cs = 4'b0011;
      set_addr(0, 14'h0AAA);
      set_addr(1, 14'h0BBB);
      tick();
      chk("rst_read0", mem_addr, 16'h0AAA);
      tick();
      rst = 1'b1;
      tick();
      chk("rst_valid", rd_valid, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, 0);
      rst = 1'b0;
      tick();
      chk("rst_restart_rd", mem_rd, 1);
      chk("rst_restart_port0", mem_addr, 16'h0AAA);
      // persistent misses on ports 0 and 3 must alternate
      do_reset();
      req_cs = 4'b1001;
      a0 = 14'h0100;
      a3 = 14'h2000;
      gq.delete();
      for (int c = 0; c < 40; c++) begin
         set_addr(0, a0 + 14'(c));
         set_addr(3, a3 + 14'(c));
         tick();
         if (mem_rd) gq.push_back(mem_addr[15:14]);
      end
      chk("starve_grant_count", gq.size() >= 12, 1);
      for (int i = 0; i < gq.size(); i++) chk("starve_alternate", gq[i], i % 2 == 0 ? 2'd0 : 2'd3);
      // random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst = $urandom_range(0, 199) == 0;
         for (int p = 0; p < 4; p++) begin
            req_cs[p] = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 3) == 0) set_addr(p, 14'($urandom_range(0, 3)));
         end
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
